// File: rtl/counter.sv
// Free-running wrapping binary counter, up or down by STEP modulo MODULUS.
// Asynchronous active-low reset loads INIT.
module counter #(
   parameter int     WIDTH   = 8,
   parameter longint INIT    = 0,
   parameter longint MODULUS = longint'(1) << WIDTH,
   parameter longint STEP    = 1,
   parameter bit     DOWN    = 1'b0
) (
   output logic [WIDTH-1:0] value,
   input  logic             clk,
   input  logic             reset
);

   localparam longint FULL = longint'(1) << WIDTH;

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "counter: WIDTH must be 1..32");
   end
   if (MODULUS < 2 || MODULUS > FULL) begin : g_bad_mod
      $fatal(1, "counter: MODULUS must be 2..2**WIDTH");
   end
   if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
      $fatal(1, "counter: INIT must be 0..MODULUS-1");
   end
   if (STEP < 1 || STEP >= MODULUS) begin : g_bad_step
      $fatal(1, "counter: STEP must be 1..MODULUS-1");
   end

   localparam logic [WIDTH:0]   MODW  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   STEPW = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   LAST  = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] INITW = WIDTH'(INIT);

   logic [WIDTH:0] ext;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] nxt;

   // One spare bit keeps value+STEP and value+MODULUS from overflowing.
   always_comb begin
      ext = {1'b0, value};
      sum = '0;
      nxt = '0;
      if (DOWN) begin
         if (ext >= STEPW) begin
            nxt = ext - STEPW;
         end else begin
            sum = ext + MODW;
            nxt = sum - STEPW;
         end
      end else begin
         sum = ext + STEPW;
         nxt = (sum > LAST) ? sum - MODW : sum;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value <= INITW;
      end else begin
         value <= nxt[WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: defaults, async reset, wrap, and
// WIDTH=4 / MODULUS=10 / STEP=3 instances counting up and down.
module tb_counter;

   logic       clk;
   logic       reset;
   logic [7:0] v8;
   logic [3:0] vup;
   logic [3:0] vdn;

   int compared;
   int mismatched;

   logic [3:0] up_seq [0:10];
   logic [3:0] dn_seq [0:10];

   counter u_def (
      .value (v8),
      .clk   (clk),
      .reset (reset)
   );

   counter #(
      .WIDTH   (4),
      .INIT    (0),
      .MODULUS (10),
      .STEP    (3),
      .DOWN    (1'b0)
   ) u_up (
      .value (vup),
      .clk   (clk),
      .reset (reset)
   );

   counter #(
      .WIDTH   (4),
      .INIT    (0),
      .MODULUS (10),
      .STEP    (3),
      .DOWN    (1'b1)
   ) u_dn (
      .value (vdn),
      .clk   (clk),
      .reset (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      up_seq = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd2, 4'd5,
                 4'd8, 4'd1, 4'd4, 4'd7, 4'd0};
      dn_seq = '{4'd0, 4'd7, 4'd4, 4'd1, 4'd8, 4'd5,
                 4'd2, 4'd9, 4'd6, 4'd3, 4'd0};

      // reset low 0..17, edges at 5 and 15 held at INIT
      reset = 1'b0;
      #10;
      check("rst_def", 32'(v8), 32'h00);
      check("rst_up", 32'(vup), 32'h0);
      check("rst_dn", 32'(vdn), 32'h0);
      #7;
      reset = 1'b1;

      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("def_%0d", k), 32'(v8), 32'(k));
         check($sformatf("up_%0d", k), 32'(vup), 32'(up_seq[k]));
         check($sformatf("dn_%0d", k), 32'(vdn), 32'(dn_seq[k]));
      end
      check("def_after10", 32'(v8), 32'h0A);

      // restart from INIT and reach 0x05
      #3;
      reset = 1'b0;
      #1;
      check("rst_restart", 32'(v8), 32'h00);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("count_5", 32'(v8), 32'h05);

      // async reset between edges
      #3;
      reset = 1'b0;
      #0;
      #1;
      check("async_mid", 32'(v8), 32'h00);
      check("async_mid_up", 32'(vup), 32'h0);
      @(posedge clk);
      #1;
      check("hold_edge1", 32'(v8), 32'h00);
      @(posedge clk);
      #1;
      check("hold_edge2", 32'(v8), 32'h00);
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("release_1", 32'(v8), 32'h01);

      // wrap from reset
      #3;
      reset = 1'b0;
      #1;
      reset = 1'b1;
      repeat (255) @(posedge clk);
      #1;
      check("wrap_ff", 32'(v8), 32'hFF);
      @(posedge clk);
      #1;
      check("wrap_00", 32'(v8), 32'h00);
      @(posedge clk);
      #1;
      check("wrap_01", 32'(v8), 32'h01);

      // release coincident with an edge: that edge still in reset
      #3;
      reset = 1'b0;
      @(posedge clk);
      reset <= 1'b1;
      #1;
      check("coinc_rel", 32'(v8), 32'h00);
      check("coinc_rel_up", 32'(vup), 32'h0);
      check("coinc_rel_dn", 32'(vdn), 32'h0);
      @(posedge clk);
      #1;
      check("coinc_next", 32'(v8), 32'h01);
      check("coinc_next_up", 32'(vup), 32'h3);
      check("coinc_next_dn", 32'(vdn), 32'h7);

      // assertion coincident with an edge: reset wins
      @(posedge clk);
      #1;
      check("pre_assert", 32'(v8), 32'h02);
      @(posedge clk);
      reset <= 1'b0;
      #1;
      check("coinc_assert", 32'(v8), 32'h00);
      check("coinc_assert_dn", 32'(vdn), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
